// File: rtl/dual_port_bram.sv
// -----------------------------------------------------------------------------
// dual_port_bram
// Simple dual-port block RAM: one write port and one read port on one clock.
// Per-byte write enables, selectable same-address collision policy, optional
// second read stage, hardware zero-fill sequencer, read-valid tracking and
// out-of-range address detection (relevant when Depth is not a power of two).
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset (memory contents are not reset)
//   clear_i     one-cycle pulse, starts a zero-fill of the whole memory
//   busy_o      high while the zero-fill runs (decoded from the state register)
//   wr_en_i     write request
//   wr_addr_i   write word address
//   wr_be_i     byte enables, bit k selects wr_data_i[8k+7:8k]
//   wr_data_i   write data
//   rd_en_i     read request
//   rd_addr_i   read word address
//   rd_data_o   read data, holds its value while rd_valid_o is low
//   rd_valid_o  high in the cycle rd_data_o carries a requested word
//   addr_err_o  one-cycle pulse after an out-of-range request
// -----------------------------------------------------------------------------
module dual_port_bram #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Depth        = 1024,
  parameter int unsigned OutputReg    = 0,
  parameter int unsigned WriteFirst   = 1,
  parameter int unsigned ClearOnReset = 1,
  localparam int unsigned AW          = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned NumBytes    = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  output logic                 busy_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [NumBytes-1:0]  wr_be_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 addr_err_o
);

  // One extra bit so Depth itself is representable for range checks.
  localparam logic [AW:0]   DepthExt = (AW+1)'(Depth);
  localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_pend_q;

  logic [DataWidth-1:0] mem [Depth];

  logic                 busy;
  logic                 wr_in_range;
  logic                 rd_in_range;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 collide;
  logic                 err_d;
  logic [DataWidth-1:0] rd_raw;
  logic [DataWidth-1:0] rd_merged;
  logic [DataWidth-1:0] rd_word;

  logic                 s1_valid_q;
  logic [DataWidth-1:0] s1_data_q;
  logic                 err_q;

  // Request qualification; everything from the ports is ignored while clearing.
  assign busy        = (state_q == ST_CLEAR);
  assign busy_o      = busy;
  assign wr_in_range = ({1'b0, wr_addr_i} < DepthExt);
  assign rd_in_range = ({1'b0, rd_addr_i} < DepthExt);
  assign wr_fire     = wr_en_i & ~busy & wr_in_range;
  assign rd_fire     = rd_en_i & ~busy;
  assign collide     = wr_fire & rd_en_i & rd_in_range & (wr_addr_i == rd_addr_i);
  // Both ports offending in one cycle still yield a single pulse.
  assign err_d       = ~busy & ((wr_en_i & ~wr_in_range) | (rd_en_i & ~rd_in_range));

  // Clear sequencer state register; the post-reset clear is a one-shot flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      init_pend_q <= (ClearOnReset != 0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_pend_q <= 1'b0;
    end
  end

  // Clear sequencer next state: one word per cycle, Depth cycles in total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_i || init_pend_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LastAddr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage: zero-fill while clearing, otherwise byte-enabled writes.
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < int'(NumBytes); k++) begin
        if (wr_be_i[k]) begin
          mem[wr_addr_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Read word selection, including write-first bypass on a collision.
  always_comb begin
    rd_raw    = mem[rd_addr_i];
    rd_merged = rd_raw;
    for (int k = 0; k < int'(NumBytes); k++) begin
      if (wr_be_i[k]) begin
        rd_merged[8*k +: 8] = wr_data_i[8*k +: 8];
      end
    end
    if (!rd_in_range) begin
      rd_word = '0;
    end else if ((WriteFirst != 0) && collide) begin
      rd_word = rd_merged;
    end else begin
      rd_word = rd_raw;
    end
  end

  // First read stage and error pulse; data only moves on an accepted read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= rd_fire;
      err_q      <= err_d;
      if (rd_fire) begin
        s1_data_q <= rd_word;
      end
    end
  end

  assign addr_err_o = err_q;

  // Optional second read stage.
  if (OutputReg != 0) begin : g_out_reg
    logic                 s2_valid_q;
    logic [DataWidth-1:0] s2_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rd_valid_o = s2_valid_q;
    assign rd_data_o  = s2_data_q;
  end else begin : g_no_out_reg
    assign rd_valid_o = s1_valid_q;
    assign rd_data_o  = s1_data_q;
  end

endmodule

// File: doc/dual_port_bram.md
Name: dual_port_bram

Overview:
Simple dual-port block RAM with one write port and one read port, both on the same clock. It supersedes the single-port BRAM for weight and activation buffers that must be written and read in the same cycle. Over the single-port version it adds per-byte write enables, a selectable collision mode and optional output registering. It also adds a hardware clear sequencer, read-valid tracking and out-of-range address detection.

Parameters:
DataWidth, 32, word width in bits; must be a multiple of 8.
Depth, 1024, number of words; need not be a power of two.
OutputReg, 0, 1 adds a second read pipeline stage (read latency 2); 0 gives latency 1.
WriteFirst, 1, same-address collision policy: 1 returns new data, 0 returns old data.
ClearOnReset, 1, 1 runs a full memory clear automatically after reset deasserts.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_ni  in  1  reset; asynchronous, active-low.
clear_i  in  1  one-cycle pulse; starts a zero-fill of the whole memory.
busy_o  out  1  high while the clear sequence runs.
wr_en_i  in  1  write request.
wr_addr_i  in  $clog2(Depth)  write word address (AW below).
wr_be_i  in  DataWidth/8  byte enables; bit k selects data bits [8k+7:8k].
wr_data_i  in  DataWidth  write data.
rd_en_i  in  1  read request.
rd_addr_i  in  AW  read word address.
rd_data_o  out  DataWidth  read data, valid when rd_valid_o is high.
rd_valid_o  out  1  high exactly in the cycle rd_data_o holds a requested word.
addr_err_o  out  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - rd_data_o=0, rd_valid_o=0, addr_err_o=0, pipeline valids=0, clear counter=0.
  - FSM goes to IDLE.
  - Memory contents are not reset.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_i=1, or on the first cycle after reset release when ClearOnReset=1.
  - CLEAR writes 0 to address cnt and increments cnt each cycle.
  - CLEAR -> IDLE after writing address Depth-1; the clear takes exactly Depth cycles.
  - cnt resets to 0 on CLEAR entry.
- busy_o = (state==CLEAR); combinational from the state register.
- While busy_o=1:
  - wr_en_i, rd_en_i and clear_i are ignored.
  - No rd_valid_o is generated and addr_err_o stays 0.
  - Reads already in flight before CLEAR entry complete normally.
- Reset asserted mid-clear aborts the sequence. After release, the clear restarts from address 0 only if ClearOnReset=1; otherwise remaining words keep stale data.
- Write: on a clock edge with wr_en_i=1, busy_o=0 and wr_addr_i<Depth, bytes with wr_be_i[k]=1 are updated. Other bytes are unchanged. wr_be_i=0 is a legal no-op.
- Read: rd_en_i=1 with rd_addr_i<Depth gives rd_data_o/rd_valid_o at edge N+1 (OutputReg=0) or N+2 (OutputReg=1).
  - Full throughput: one read per cycle, back-to-back.
  - When rd_valid_o=0, rd_data_o holds its previous value.
- Collision (same cycle, same in-range address, both enabled):
  - WriteFirst=1: read returns the stored word merged with the new enabled bytes.
  - WriteFirst=0: read returns the pre-write word.
- Out-of-range (addr >= Depth, possible when Depth is not a power of two):
  - Write is dropped.
  - Read still produces rd_valid_o with rd_data_o=0.
  - addr_err_o pulses one cycle after the offending edge. Two offending requests in the same cycle produce a single pulse.

Test Plan:
- Depth=1024, ClearOnReset=1: release reset -> busy_o high exactly 1024 cycles; afterwards a read of every address returns 0 with rd_valid_o.
- Write 0xDEADBEEF at addr 5 with be=4'hF, then be=4'b0010 with data 0x0000AA00 -> read addr 5 returns 0xDEADAAEF, with latency 1 (OutputReg=0) and 2 (OutputReg=1).
- Read addr 7 (holding 0x11111111) while writing 0x22222222 there in the same cycle -> returns 0x22222222 when WriteFirst=1, 0x11111111 when WriteFirst=0.
- Depth=1000: write and read addr 1000 -> memory unchanged, rd_data_o=0 with rd_valid_o, addr_err_o one-cycle pulse.
- Back-to-back reads of addrs 0..15, with rd_en_i dropped every 4th cycle -> rd_valid_o pattern mirrors rd_en_i delayed by the latency, data in order.
- Pulse clear_i, then assert rst_ni=0 at cycle 300 of the clear -> outputs zero immediately; with ClearOnReset=0, no clear after release and addr 500 keeps its old data.
